// File: rtl/regfile_sb.sv
// Register file with optional hardwired-zero r0 and write bypass, plus a per-register
// pending scoreboard used by decode to stall on RAW hazards.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg1,
    input  logic [ADDR_W-1:0] reg2,
    output logic [DATA_W-1:0] read1,
    output logic [DATA_W-1:0] read2,
    output logic              busy1,
    output logic              busy2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] issueReg,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DEPTH-1:0]  w_pend_d;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_d;
    logic              w_wr_en;
    logic              w_iss_en;
    logic              w_inc;
    logic              w_dec;

    always_comb begin
        w_wr_en  = RegWrite && !(ZERO_REG != 0 && writeReg == '0);
        w_iss_en = IssueEn && !(ZERO_REG != 0 && issueReg == '0);

        // Clear first, then set: a same-cycle issue supersedes the retiring writeback.
        w_pend_d = r_pend;
        if (RegWrite) begin
            w_pend_d[writeReg] = 1'b0;
        end
        if (w_iss_en) begin
            w_pend_d[issueReg] = 1'b1;
        end

        w_inc = w_iss_en && !r_pend[issueReg];
        w_dec = RegWrite && r_pend[writeReg] && !(w_iss_en && issueReg == writeReg);

        w_cnt_d = r_cnt;
        if (w_inc && !w_dec) begin
            w_cnt_d = r_cnt + CNT_ONE;
        end else if (w_dec && !w_inc) begin
            w_cnt_d = r_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[writeReg] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_pend_d;
            r_cnt  <= w_cnt_d;
        end
    end

    // Bypass is gated by rst_n so reads stay zero while reset is held.
    always_comb begin
        read1 = r_regs[reg1];
        if (BYPASS != 0 && rst_n && RegWrite && writeReg == reg1) begin
            read1 = WriteData;
        end
        if (ZERO_REG != 0 && reg1 == '0) begin
            read1 = '0;
        end
    end

    always_comb begin
        read2 = r_regs[reg2];
        if (BYPASS != 0 && rst_n && RegWrite && writeReg == reg2) begin
            read2 = WriteData;
        end
        if (ZERO_REG != 0 && reg2 == '0) begin
            read2 = '0;
        end
    end

    assign busy1    = r_pend[reg1];
    assign busy2    = r_pend[reg2];
    assign pend_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: instance 0 uses ZERO_REG=1/BYPASS=1, instance 1 uses ZERO_REG=0/BYPASS=0;
// both share inputs and are compared against an array-based reference model.
module tb_regfile_sb;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [4:0]        reg1 = '0;
    logic [4:0]        reg2 = '0;
    logic [4:0]        writeReg = '0;
    logic [4:0]        issueReg = '0;
    logic              RegWrite = 1'b0;
    logic              IssueEn = 1'b0;
    logic [31:0]       WriteData = '0;
    logic [1:0][31:0]  rd1;
    logic [1:0][31:0]  rd2;
    logic [1:0]        bz1;
    logic [1:0]        bz2;
    logic [1:0][5:0]   cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [2][32];
    logic        m_pend [2][32];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .reg1(reg1), .reg2(reg2),
        .read1(rd1[0]), .read2(rd2[0]), .busy1(bz1[0]), .busy2(bz2[0]),
        .RegWrite(RegWrite), .writeReg(writeReg), .WriteData(WriteData),
        .IssueEn(IssueEn), .issueReg(issueReg), .pend_cnt(cnt[0])
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .reg1(reg1), .reg2(reg2),
        .read1(rd1[1]), .read2(rd2[1]), .busy1(bz1[1]), .busy2(bz2[1]),
        .RegWrite(RegWrite), .writeReg(writeReg), .WriteData(WriteData),
        .IssueEn(IssueEn), .issueReg(issueReg), .pend_cnt(cnt[1])
    );

    function automatic bit cfg_zero(int c);
        return c == 0;
    endfunction

    function automatic bit cfg_byp(int c);
        return c == 0;
    endfunction

    function automatic logic [31:0] exp_read(int c, logic [4:0] a);
        if (!rst_n) return 32'h0;
        if (cfg_zero(c) && a == 5'd0) return 32'h0;
        if (cfg_byp(c) && RegWrite && writeReg == a) return WriteData;
        return m_regs[c][a];
    endfunction

    function automatic logic [5:0] exp_cnt(int c);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[c][i]);
        return 6'(n);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[c][i] = '0;
                m_pend[c][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (RegWrite && !(cfg_zero(c) && writeReg == 5'd0)) m_regs[c][writeReg] = WriteData;
            if (RegWrite) m_pend[c][writeReg] = 1'b0;
            if (IssueEn && !(cfg_zero(c) && issueReg == 5'd0)) m_pend[c][issueReg] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0;
        IssueEn  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        reg1 = 5'd7;
        reg2 = 5'd31;
        RegWrite = 1'b1;
        writeReg = 5'd7;
        WriteData = 32'hCAFE_F00D;
        tick();
        tick();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rd1[c] !== 32'h0) begin
                failures++;
                $display("FAIL reset_read1 dut%0d: got %h expected 0", c, rd1[c]);
            end
            checks++;
            if (rd2[c] !== 32'h0) begin
                failures++;
                $display("FAIL reset_read2 dut%0d: got %h expected 0", c, rd2[c]);
            end
            checks++;
            if (bz1[c] !== 1'b0 || bz2[c] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy dut%0d: got %b%b expected 00", c, bz1[c], bz2[c]);
            end
            checks++;
            if (cnt[c] !== 6'd0) begin
                failures++;
                $display("FAIL reset_cnt dut%0d: got %0d expected 0", c, cnt[c]);
            end
        end
        idle();
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rd1[c] !== 32'h0) begin
                failures++;
                $display("FAIL reset_write_dropped dut%0d: got %h expected 0", c, rd1[c]);
            end
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1;
        writeReg = 5'd1;
        WriteData = 32'h1110_0000;
        tick();
        idle();
        reg1 = 5'd1;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rd1[c] !== 32'h1110_0000) begin
                failures++;
                $display("FAIL write_read dut%0d: got %h expected 11100000", c, rd1[c]);
            end
        end
        RegWrite = 1'b1;
        writeReg = 5'd3;
        WriteData = 32'h1000_0000;
        reg2 = 5'd3;
        #1;
        checks++;
        if (rd2[0] !== 32'h1000_0000) begin
            failures++;
            $display("FAIL bypass_on dut0: got %h expected 10000000", rd2[0]);
        end
        checks++;
        if (rd2[1] !== 32'h0) begin
            failures++;
            $display("FAIL bypass_off dut1: got %h expected 0", rd2[1]);
        end
        tick();
        idle();
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rd2[c] !== 32'h1000_0000) begin
                failures++;
                $display("FAIL after_edge dut%0d: got %h expected 10000000", c, rd2[c]);
            end
        end
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1;
        writeReg = 5'd0;
        WriteData = 32'hDEAD_BEEF;
        IssueEn = 1'b1;
        issueReg = 5'd0;
        reg1 = 5'd0;
        #1;
        checks++;
        if (rd1[0] !== 32'h0) begin
            failures++;
            $display("FAIL zero_no_bypass dut0: got %h expected 0", rd1[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd1[0] !== 32'h0 || bz1[0] !== 1'b0 || cnt[0] !== 6'd0) begin
            failures++;
            $display("FAIL zero_reg dut0: got read=%h busy=%b cnt=%0d expected 0/0/0",
                     rd1[0], bz1[0], cnt[0]);
        end
        checks++;
        if (rd1[1] !== 32'hDEAD_BEEF || bz1[1] !== 1'b1 || cnt[1] !== 6'd1) begin
            failures++;
            $display("FAIL plain_r0 dut1: got read=%h busy=%b cnt=%0d expected deadbeef/1/1",
                     rd1[1], bz1[1], cnt[1]);
        end
    endtask

    task automatic test_scoreboard();
        IssueEn = 1'b1;
        issueReg = 5'd5;
        tick();
        idle();
        reg1 = 5'd5;
        #1;
        checks++;
        if (bz1[0] !== 1'b1 || cnt[0] !== 6'd1 || cnt[1] !== 6'd2) begin
            failures++;
            $display("FAIL issue_r5: got busy=%b cnt0=%0d cnt1=%0d expected 1/1/2",
                     bz1[0], cnt[0], cnt[1]);
        end
        RegWrite = 1'b1;
        writeReg = 5'd5;
        WriteData = 32'h0000_0010;
        #1;
        checks++;
        if (bz1[0] !== 1'b1 || rd1[0] !== 32'h10 || rd1[1] !== 32'h0) begin
            failures++;
            $display("FAIL wb_cycle: got busy=%b rd0=%h rd1=%h expected 1/10/0",
                     bz1[0], rd1[0], rd1[1]);
        end
        tick();
        idle();
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bz1[c] !== 1'b0 || rd1[c] !== 32'h10 || cnt[c] !== 6'(c)) begin
                failures++;
                $display("FAIL wb_done dut%0d: got busy=%b read=%h cnt=%0d expected 0/10/%0d",
                         c, bz1[c], rd1[c], cnt[c], c);
            end
        end
    endtask

    task automatic test_simultaneous();
        IssueEn = 1'b1;
        issueReg = 5'd4;
        tick();
        RegWrite = 1'b1;
        writeReg = 5'd4;
        WriteData = 32'h1;
        tick();
        idle();
        reg1 = 5'd4;
        reg2 = 5'd6;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rd1[c] !== 32'h1 || bz1[c] !== 1'b1 || cnt[c] !== 6'(c + 1)) begin
                failures++;
                $display("FAIL set_wins dut%0d: got read=%h busy=%b cnt=%0d expected 1/1/%0d",
                         c, rd1[c], bz1[c], cnt[c], c + 1);
            end
        end
        IssueEn = 1'b1;
        issueReg = 5'd6;
        RegWrite = 1'b1;
        writeReg = 5'd4;
        WriteData = 32'h2;
        tick();
        idle();
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bz1[c] !== 1'b0 || bz2[c] !== 1'b1 || cnt[c] !== 6'(c + 1) || rd1[c] !== 32'h2)
            begin
                failures++;
                $display("FAIL set_clear_net0 dut%0d: got b4=%b b6=%b cnt=%0d rd=%h exp 0/1/%0d/2",
                         c, bz1[c], bz2[c], cnt[c], rd1[c], c + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int r = 1; r <= 3; r++) begin
            RegWrite = 1'b1;
            writeReg = 5'(r);
            WriteData = 32'h100 * r;
            IssueEn = 1'b1;
            issueReg = 5'(r);
            tick();
        end
        idle();
        reg1 = 5'd1;
        reg2 = 5'd2;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bz1[c] !== 1'b1 || rd2[c] !== 32'h200 || cnt[c] !== exp_cnt(c)) begin
                failures++;
                $display("FAIL pre_reset dut%0d: got busy=%b rd=%h cnt=%0d expected 1/200/%0d",
                         c, bz1[c], rd2[c], cnt[c], exp_cnt(c));
            end
        end
        #2;
        RegWrite = 1'b1;
        writeReg = 5'd2;
        WriteData = 32'hAAAA_5555;
        IssueEn = 1'b1;
        issueReg = 5'd9;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rd1[c] !== 32'h0 || rd2[c] !== 32'h0 || bz1[c] !== 1'b0 || cnt[c] !== 6'd0) begin
                failures++;
                $display("FAIL async_reset dut%0d: got rd1=%h rd2=%h busy=%b cnt=%0d exp all 0",
                         c, rd1[c], rd2[c], bz1[c], cnt[c]);
            end
        end
        tick();
        idle();
        rst_n = 1'b1;
        reg1 = 5'd9;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rd2[c] !== 32'h0 || bz1[c] !== 1'b0 || cnt[c] !== 6'd0) begin
                failures++;
                $display("FAIL reset_discard dut%0d: got rd2=%h busy9=%b cnt=%0d expected 0/0/0",
                         c, rd2[c], bz1[c], cnt[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RegWrite  = 1'($urandom_range(0, 1));
            IssueEn   = 1'($urandom_range(0, 1));
            WriteData = $urandom;
            writeReg  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
            issueReg  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
            reg1      = ($urandom_range(0, 2) == 0) ? writeReg : 5'($urandom_range(0, 7));
            reg2      = 5'($urandom_range(0, 31));
            #1;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (rd1[c] !== exp_read(c, reg1) || rd2[c] !== exp_read(c, reg2)) begin
                    failures++;
                    $display("FAIL rand_read dut%0d it%0d: got %h/%h expected %h/%h", c, n,
                             rd1[c], rd2[c], exp_read(c, reg1), exp_read(c, reg2));
                end
                checks++;
                if (bz1[c] !== m_pend[c][reg1] || bz2[c] !== m_pend[c][reg2]) begin
                    failures++;
                    $display("FAIL rand_busy dut%0d it%0d: got %b%b expected %b%b", c, n,
                             bz1[c], bz2[c], m_pend[c][reg1], m_pend[c][reg2]);
                end
                checks++;
                if (cnt[c] !== exp_cnt(c)) begin
                    failures++;
                    $display("FAIL rand_cnt dut%0d it%0d: got %0d expected %0d", c, n,
                             cnt[c], exp_cnt(c));
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
